// File: rtl/expand_key_pkg.sv
// Shared constants for the AES-256 key expansion: forward S-box, Rcon and schedule sizes.
package expand_key_pkg;

  localparam int NK        = 8;
  localparam int NR        = 14;
  localparam int NUM_WORDS = 60;

  // Rcon[j] is only ever needed for j = 1..7 with a 256-bit key.
  localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES forward S-box to each byte of a 32-bit word.
module aes_sub_word
  import expand_key_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/expand_key.sv
// AES-256 key schedule, fully unrolled into one combinational stage.
// Build option: define EXPAND_KEY_OUTREG_EN to register key_out (1-cycle latency, async active-low reset).
module expand_key
  import expand_key_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  output logic [127:0] key_out [NR:0]
);

  logic [127:0] key_d [NR:0];

  // Each word lives in its own generate scope so the 60-deep chain is not one self-referencing array.
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_w
    logic [31:0] w;
    if (i < NK) begin : g_key
      assign w = key_in[255-32*i -: 32];
    end else if (i % NK == 0) begin : g_rot
      logic [31:0] prev;
      logic [31:0] sub;
      assign prev = g_w[i-1].w;
      aes_sub_word u_sub_word (
        .word_i ({prev[23:0], prev[31:24]}),
        .word_o (sub)
      );
      assign w = g_w[i-NK].w ^ sub ^ {RCON[i/NK], 24'h0};
    end else if (i % NK == 4) begin : g_sub
      logic [31:0] sub;
      aes_sub_word u_sub_word (
        .word_i (g_w[i-1].w),
        .word_o (sub)
      );
      assign w = g_w[i-NK].w ^ sub;
    end else begin : g_xor
      assign w = g_w[i-NK].w ^ g_w[i-1].w;
    end
  end

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign key_d[r] = {g_w[4*r].w, g_w[4*r+1].w, g_w[4*r+2].w, g_w[4*r+3].w};
  end

`ifdef EXPAND_KEY_OUTREG_EN
  logic [127:0] key_q [NR:0];

  // NOTE: this array is ordinary flops, so it is reset explicitly; outputs must read zero the moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r <= NR; r++) key_q[r] <= '0;
    end else begin
      for (int r = 0; r <= NR; r++) key_q[r] <= key_d[r];
    end
  end

  assign key_out = key_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign key_out        = key_d;
`endif

endmodule

// File: tb/tb_expand_key.sv
// Randomized bench for expand_key; S-box and Rcon are rebuilt from GF(2^8) arithmetic, independent of the RTL tables.
module tb_expand_key;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic [127:0] key_out [14:0];

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk   [15];
  int           checks   = 0;
  int           failures = 0;

  expand_key dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .key_out (key_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bx  = 8'(x);
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_ref[v[31:24]], sbox_ref[v[23:16]], sbox_ref[v[15:8]], sbox_ref[v[7:0]]};
  endfunction

  function automatic void compute_expected(input logic [255:0] k);
    logic [31:0] w [60];
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      if (i % 8 == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / 8; j++) rc = gmul(rc, 8'h02);
        w[i] = w[i-8] ^ sub_word({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        w[i] = w[i-8] ^ sub_word(w[i-1]);
      end else begin
        w[i] = w[i-8] ^ w[i-1];
      end
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check_all(input string tag);
    for (int r = 0; r < 15; r++) check($sformatf("%s_rk%0d", tag, r), key_out[r], exp_rk[r]);
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < 15; r++) check($sformatf("%s_rk%0d", tag, r), key_out[r], 128'h0);
  endtask

  // Registered build: drive at the falling edge, check just after the next rising edge,
  // so consecutive calls present a new key every cycle.
  task automatic apply(input logic [255:0] k, input string tag);
`ifdef EXPAND_KEY_OUTREG_EN
    @(negedge clk);
    key_in = k;
    compute_expected(k);
    @(posedge clk);
    #1;
`else
    key_in = k;
    compute_expected(k);
    #1;
`endif
    check_all(tag);
  endtask

  localparam logic [255:0] K_A = 256'h1212121269696969343434343434343456565656565656567878787878787878;
  localparam logic [255:0] K_Z = 256'h0;
  localparam logic [255:0] K_F = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    rst    = 1'b0;
    key_in = K_A;
    build_sbox();

`ifdef EXPAND_KEY_OUTREG_EN
    #1;
    check_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
`else
    rst = 1'b1;
`endif

    apply(K_A, "vec_a");
    check("vec_a_rk8", key_out[8], 128'h981ccf1e5edf501fb532e109b536b9cf);
    apply(K_Z, "vec_zero");
    check("vec_zero_rk0", key_out[0], 128'h0);
    check("vec_zero_rk1", key_out[1], 128'h0);
    check("vec_zero_rk2", key_out[2], 128'h62636363626363636263636362636363);
    check("vec_zero_rk3", key_out[3], 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
    apply(K_F, "vec_fips");
    check("vec_fips_rk14", key_out[14], 128'hfe4890d1e6188d0b046df344706c631e);
    apply({256{1'b1}}, "vec_ones");

    for (int n = 0; n < 30; n++) begin
      logic [255:0] k;
      for (int b = 0; b < 8; b++) k[32*b +: 32] = $urandom;
      apply(k, $sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_hi", n), key_out[0], k[255:128]);
      check($sformatf("rnd%0d_lo", n), key_out[1], k[127:0]);
    end

`ifdef EXPAND_KEY_OUTREG_EN
    // Reset arriving between edges must clear outputs at once and drop the pending key.
    @(negedge clk);
    key_in = K_F;
    #2;
    rst = 1'b0;
    #1;
    check_zero("rst_mid_async");
    @(posedge clk);
    #1;
    check_zero("rst_mid_edge");
    @(negedge clk);
    rst = 1'b1;
    compute_expected(K_F);
    @(posedge clk);
    #1;
    check_all("rst_release");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
